instr_decode_buf: RTL

- Next-generation instruction decoder for the RISC datapath: registers incoming 16-bit instructions and decodes them into a parametrised-depth FIFO.
- Uses a valid/ready handshake on both sides, so fetch and the controller FSM can stall independently.
- Sign-extended immediates are generalised to DATA_W bits.
- Register-number selection (nsel) is applied combinationally to the decoded entry at the FIFO head.

---
 rtl/instr_dec_pkg.sv | 73 +++++++
 rtl/instr_field_decode.sv | 53 +++++
 rtl/instr_decode_buf.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/instr_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_dec_pkg
//  Purpose  : Shared opcode/op constants, nsel one-hot codes, instruction
//             field bit positions and the decoded-record type used by the
//             instruction decode buffer.
//  Ports    : (package - none)
//  Revision : 1.0 - initial release
// ============================================================================
package instr_dec_pkg;

  // Opcode field values (instr[15:13])
  localparam logic [2:0] OPC_BRANCH = 3'b001;
  localparam logic [2:0] OPC_CALL   = 3'b010;
  localparam logic [2:0] OPC_LDR    = 3'b011;
  localparam logic [2:0] OPC_STR    = 3'b100;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_HALT   = 3'b111;

  // Op field values (instr[12:11]) for the exact-match legal classes
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MEM     = 2'b00;

  // One-hot register selects
  localparam logic [2:0] NSEL_RM = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RN = 3'b100;

  // Field bit positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;

  // Decoded record stored per FIFO entry (immediates kept separately
  // because their width follows the DATA_W parameter)
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] shift;
  } dec_rec_t;

  // Memory and the 01000 class ignore the shift field
  function automatic logic shift_forced(input logic [2:0] opc, input logic [1:0] op);
    return ({opc, op} == {OPC_LDR, OP_MEM}) ||
           ({opc, op} == {OPC_STR, OP_MEM}) ||
           ({opc, op} == {OPC_CALL, 2'b00});
  endfunction

  function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
    return ({opc, op} == {OPC_MOV, OP_MOV_IMM}) ||
           ({opc, op} == {OPC_MOV, OP_MOV_REG}) ||
           ({opc, op} == {OPC_LDR, OP_MEM})     ||
           ({opc, op} == {OPC_STR, OP_MEM})     ||
           (opc == OPC_ALU) || (opc == OPC_HALT) ||
           (opc == OPC_BRANCH) || (opc == OPC_CALL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_field_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_field_decode
//  Purpose  : Combinational decode of a 16-bit instruction into a record:
//             register fields, forced shift, sign-extended immediates and
//             (when INSTR_DEC_ILLEGAL_EN is defined) an illegal flag.
//  Ports    : instr   - raw instruction word
//             rec     - decoded fields
//             sximm5  - instr[4:0] sign-extended to DATA_W
//             sximm8  - instr[7:0] sign-extended to DATA_W
//             illegal - {opcode,op} outside legal set (macro builds only)
//  Revision : 1.0 - initial release
// ============================================================================
module instr_field_decode
  import instr_dec_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       instr,
  output dec_rec_t          rec,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
`ifdef INSTR_DEC_ILLEGAL_EN
  ,
  output logic              illegal
`endif
);

  logic [2:0] opc;
  logic [1:0] op;

  assign opc = instr[OPC_HI:OPC_LO];
  assign op  = instr[OP_HI:OP_LO];

  always_comb begin
    rec        = '0;
    rec.opcode = opc;
    rec.op     = op;
    rec.rn     = instr[RN_HI:RN_LO];
    rec.rd     = instr[RD_HI:RD_LO];
    rec.rm     = instr[RM_HI:RM_LO];
    rec.shift  = shift_forced(opc, op) ? 2'b00 : instr[SH_HI:SH_LO];
  end

  assign sximm5 = {{(DATA_W-5){instr[4]}}, instr[4:0]};
  assign sximm8 = {{(DATA_W-8){instr[7]}}, instr[7:0]};

`ifdef INSTR_DEC_ILLEGAL_EN
  assign illegal = !is_legal(opc, op);
`endif

endmodule
`default_nettype wire

// File: rtl/instr_decode_buf.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decode_buf
//  Purpose  : Decodes incoming instructions and buffers the decoded records
//             in a BUF_DEPTH-entry FIFO with valid/ready on both sides.
//             Register selection (nsel) is a combinational mux on the head.
//  Macro    : INSTR_DEC_ILLEGAL_EN - store and report a per-entry illegal bit
//  Ports    : clk, reset (sync, active-high)
//             in_instr/in_valid/in_ready   - producer side
//             out_valid/out_ready          - consumer side
//             nsel -> readnum/writenum     - one-hot register select
//             opcode/op/ALUop/Rn/shift/sximm5/sximm8/out_illegal - head fields
//             count                        - entries held
//  Revision : 1.0 - initial release
// ============================================================================
module instr_decode_buf
  import instr_dec_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int BUF_DEPTH = 2,
  localparam int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       in_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  input  logic [2:0]        nsel,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        ALUop,
  output logic [2:0]        Rn,
  output logic [1:0]        shift,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [CNT_W-1:0]  count,
  output logic              out_illegal
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  dec_rec_t          dec_rec;
  logic [DATA_W-1:0] dec_imm5;
  logic [DATA_W-1:0] dec_imm8;

  dec_rec_t          rec_mem  [BUF_DEPTH];
  logic [DATA_W-1:0] imm5_mem [BUF_DEPTH];
  logic [DATA_W-1:0] imm8_mem [BUF_DEPTH];

  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              push;
  logic              pop;
  dec_rec_t          head_rec;

`ifdef INSTR_DEC_ILLEGAL_EN
  logic              dec_illegal;
  logic              ill_mem [BUF_DEPTH];
`endif

  instr_field_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .instr   (in_instr),
    .rec     (dec_rec),
    .sximm5  (dec_imm5),
    .sximm8  (dec_imm8)
`ifdef INSTR_DEC_ILLEGAL_EN
    ,
    .illegal (dec_illegal)
`endif
  );

  // Ready depends on occupancy only, so no out_ready -> in_ready path exists;
  // a full buffer with a pop therefore accepts again only on the next cycle.
  assign in_ready  = (cnt != CNT_W'(BUF_DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        rec_mem[i]  <= '0;
        imm5_mem[i] <= '0;
        imm8_mem[i] <= '0;
`ifdef INSTR_DEC_ILLEGAL_EN
        ill_mem[i]  <= 1'b0;
`endif
      end
    end else begin
      if (push) begin
        rec_mem[tail_ptr]  <= dec_rec;
        imm5_mem[tail_ptr] <= dec_imm5;
        imm8_mem[tail_ptr] <= dec_imm8;
`ifdef INSTR_DEC_ILLEGAL_EN
        ill_mem[tail_ptr]  <= dec_illegal;
`endif
        // power-of-two depth: natural overflow gives the modulo wrap
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head fields are driven whether or not the entry is valid; stale data
  // (never X) is visible while empty.
  assign head_rec = rec_mem[head_ptr];
  assign opcode   = head_rec.opcode;
  assign op       = head_rec.op;
  assign ALUop    = head_rec.op;
  assign Rn       = head_rec.rn;
  assign shift    = head_rec.shift;
  assign sximm5   = imm5_mem[head_ptr];
  assign sximm8   = imm8_mem[head_ptr];
  assign count    = cnt;

`ifdef INSTR_DEC_ILLEGAL_EN
  assign out_illegal = ill_mem[head_ptr];
`else
  assign out_illegal = 1'b0;
`endif

  // Only exact one-hot selects pick a register; anything else reads R0.
  always_comb begin
    readnum = 3'b000;
    case (nsel)
      NSEL_RM: readnum = head_rec.rm;
      NSEL_RD: readnum = head_rec.rd;
      NSEL_RN: readnum = head_rec.rn;
      default: readnum = 3'b000;
    endcase
  end

  assign writenum = readnum;

endmodule
`default_nettype wire
